fifo_v2: RTL and testbench
==========================

Name: fifo_v2

Overview:
Parametrised successor to the single-width queue. Synchronous FIFO with generic data width and depth, and optional fall-through mode. Valid/ready handshake on both sides, plus fill level, almost-full/almost-empty flags and a synchronous flush. Used as the standard buffering element between streaming datapath stages in one clock domain.

Parameters:
DATA_WIDTH, 32, width of one entry in bits (matches word_t).
DEPTH, 8, number of entries; legal range 2..1024; need not be a power of two.
FALL_THROUGH, 0, 1 = an empty FIFO forwards the pushed word to the output in the same cycle.
ALMOST_FULL_TH, DEPTH-1, almost_full_o asserted when usage_o >= this value.
ALMOST_EMPTY_TH, 1, almost_empty_o asserted when usage_o <= this value.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
flush_i  input  1  synchronous clear of contents; no reset of storage RAM needed
in_valid_i  input  1  push request
in_ready_o  output  1  FIFO can accept (= !full)
in_data_i  input  DATA_WIDTH  push data
out_valid_o  output  1  data available
out_ready_i  input  1  consumer accepts
out_data_o  output  DATA_WIDTH  head-of-queue data
usage_o  output  $clog2(DEPTH+1)  current number of stored entries
almost_full_o  output  1  usage_o >= ALMOST_FULL_TH
almost_empty_o  output  1  usage_o <= ALMOST_EMPTY_TH

Behaviour:
- Reset (rst_i=1 at clock edge): read and write pointers are 0, count is 0. Outputs: in_ready_o=1, out_valid_o=0, usage_o=0, almost_full_o=0 (unless ALMOST_FULL_TH==0), almost_empty_o=1. out_data_o is don't-care while out_valid_o=0.
- push = in_valid_i && in_ready_o. pop = out_valid_o && out_ready_i. Transfer happens on the clock edge.
- in_ready_o = (count != DEPTH). It has no combinational dependence on out_ready_i; a full FIFO does not accept a word in the same cycle it pops one.
- Normal mode (FALL_THROUGH=0):
  - out_valid_o = (count != 0); out_data_o = mem[rptr].
  - Write-to-read latency is 1 cycle.
- Fall-through mode (FALL_THROUGH=1):
  - When count==0, out_valid_o = in_valid_i and out_data_o = in_data_i, combinationally.
  - If pop also occurs that cycle, the word bypasses storage: count stays 0 and pointers do not move.
  - Otherwise behaves as normal mode.
- Pointers wrap from DEPTH-1 to 0; no power-of-two assumption.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither (excluding the fall-through bypass case).
- usage_o, almost_full_o and almost_empty_o reflect the registered count, i.e. the state before this cycle's transfer.
- flush_i=1: behaves like reset for pointers and count on that edge and overrides any push/pop in the same cycle. The pushed word is dropped; in_ready_o is still driven from the current state.
- rst_i takes precedence over flush_i. Reset in the middle of a burst discards all contents; no partial state remains.
- out_data_o holds stable while out_valid_o=1 and out_ready_i=0 in normal mode. In fall-through mode with count==0 it follows in_data_i.

Optional Feature:
FIFO_ERR_EN
- Defined:
  - Adds outputs overflow_o and underflow_o (1 bit each), both 0 after reset or flush.
  - overflow_o sets sticky when in_valid_i=1 while in_ready_o=0.
  - underflow_o sets sticky when out_ready_i=1 while out_valid_o=0.
  - Both clear only on rst_i or flush_i.
  - Adds simulation assertions: in_data_i is stable while in_valid_i && !in_ready_o; no push when full.
- Not defined: ports and assertions are absent. Behaviour of all other ports is identical.

Test Plan:
- DEPTH=4, FT=0: push 0xA,0xB,0xC,0xD with out_ready_i=0 -> in_ready_o=0 after 4th edge, usage_o=4, almost_full_o=1 (TH=3); then pop 4 -> out_data_o sequence A,B,C,D, usage_o=0, out_valid_o=0.
- DEPTH=4, FT=0, count=2: simultaneous push 0x5 and pop for 6 cycles -> usage_o stays 2, pointers wrap, output order preserved with no loss.
- DEPTH=3 (non power of two): push 7 words interleaved with pops -> every word appears in order; usage_o never exceeds 3.
- FT=1, empty: in_valid_i=1, data 0x77, out_ready_i=1 -> out_valid_o=1 and out_data_o=0x77 in the same cycle; usage_o stays 0. Repeat with out_ready_i=0 -> word stored, usage_o=1 next cycle.
- count=3, assert flush_i with a push of 0x9 -> next cycle usage_o=0, out_valid_o=0; 0x9 never appears at out_data_o.
- With FIFO_ERR_EN defined: push while full -> overflow_o=1 and stays 1; pop while empty -> underflow_o=1; assert rst_i -> both 0.

Source files
------------

// File: rtl/fifo_v2.sv
// ---------------------------------------------------------------------------
// fifo_v2 - parametrised synchronous FIFO
//
// Standard single-clock buffering element between streaming datapath stages.
// Generic width and depth (any depth 2..1024, not restricted to powers of
// two). There is an optional fall-through mode in which an empty FIFO
// presents the incoming word on its output in the same cycle.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   flush_i        synchronous clear of contents (pointers and count)
//   in_valid_i     push request
//   in_ready_o     FIFO can accept a word (= not full)
//   in_data_i      push data
//   out_valid_o    head word available
//   out_ready_i    consumer accepts the head word
//   out_data_o     head-of-queue data
//   usage_o        number of stored entries (registered)
//   almost_full_o  usage_o >= ALMOST_FULL_TH
//   almost_empty_o usage_o <= ALMOST_EMPTY_TH
//
// Optional feature macro: FIFO_ERR_EN
//   When defined, adds the sticky error outputs overflow_o (push attempted
//   while full) and underflow_o (pop attempted while empty), which clear only
//   on rst_i or flush_i. It also adds simulation assertions on the producer
//   handshake.
// ---------------------------------------------------------------------------
module fifo_v2 #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int FALL_THROUGH    = 0,
    parameter int ALMOST_FULL_TH  = DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o
`ifdef FIFO_ERR_EN
    ,
    output logic                         overflow_o,
    output logic                         underflow_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Storage is not reset: flush and reset only move pointers and count.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic bypass_mode;
    logic push;
    logic pop;
    logic bypass_xfer;
    logic do_push;
    logic do_pop;
    logic wr_en;

    // Handshake and output selection. In fall-through mode an empty FIFO
    // exposes the input word directly; otherwise the head entry is shown.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        bypass_mode = (FALL_THROUGH != 0) && empty;

        in_ready_o  = !full;

        if (bypass_mode) begin
            out_valid_o = in_valid_i;
            out_data_o  = in_data_i;
        end else begin
            out_valid_o = !empty;
            out_data_o  = mem[rptr_q];
        end

        push = in_valid_i && in_ready_o;
        pop  = out_valid_o && out_ready_i;

        // A word pushed and popped in the same cycle through the bypass path
        // never touches storage, so neither pointer nor count moves.
        bypass_xfer = bypass_mode && push && pop;
        do_push     = push && !bypass_xfer;
        do_pop      = pop && !bypass_xfer;
        wr_en       = do_push && !flush_i && !rst_i;

        usage_o        = count_q;
        almost_full_o  = (int'(count_q) >= ALMOST_FULL_TH);
        almost_empty_o = (int'(count_q) <= ALMOST_EMPTY_TH);
    end

    // Next-state for pointers and count. Pointers wrap explicitly at
    // DEPTH-1 so non power-of-two depths work. Reset and flush both clear
    // the bookkeeping and override any transfer in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (do_push) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rst_i || flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_q] <= in_data_i;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on an attempted transfer the FIFO cannot
    // honour, cleared only by reset or flush.
    always_comb begin
        overflow_d  = overflow_q || (in_valid_i && !in_ready_o);
        underflow_d = underflow_q || (out_ready_i && !out_valid_o);
        if (rst_i || flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // A stalled producer must hold its word until it is accepted or
    // withdrawn.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (in_valid_i && !in_ready_o && !flush_i) |=>
        (!in_valid_i || $stable(in_data_i)));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full));
`endif

endmodule

// File: tb/tb_fifo_v2.sv
// ---------------------------------------------------------------------------
// tb_fifo_v2 - self-checking bench for fifo_v2
//
// Three instances share one stimulus stream:
//   inst0: DEPTH=4, normal mode, AF=3, AE=1
//   inst1: DEPTH=3, normal mode, AF=2, AE=1 (non power of two)
//   inst2: DEPTH=4, fall-through,  AF=2, AE=0
// Each instance has its own queue model. The model is evaluated on the
// falling edge, where inputs are stable, and then advanced for the coming
// rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_v2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        out_ready_i;

    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  af;
    logic [2:0]  ae;
    logic [31:0] out_data [3];
    logic [2:0]  usage_n4;
    logic [1:0]  usage_n3;
    logic [2:0]  usage_f4;
`ifdef FIFO_ERR_EN
    logic [2:0]  ovf;
    logic [2:0]  unf;
`endif

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;
    bit hold_data  = 1'b0;

    logic [31:0] q [3][$];
    bit          ov_m [3];
    bit          un_m [3];

    always #5 clk_i = ~clk_i;

    fifo_v2 #(.DATA_WIDTH(32), .DEPTH(4), .FALL_THROUGH(0),
              .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)) u_n4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[0]), .in_data_i(in_data_i),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i), .out_data_o(out_data[0]),
        .usage_o(usage_n4), .almost_full_o(af[0]), .almost_empty_o(ae[0])
`ifdef FIFO_ERR_EN
        , .overflow_o(ovf[0]), .underflow_o(unf[0])
`endif
    );

    fifo_v2 #(.DATA_WIDTH(32), .DEPTH(3), .FALL_THROUGH(0),
              .ALMOST_FULL_TH(2), .ALMOST_EMPTY_TH(1)) u_n3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[1]), .in_data_i(in_data_i),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i), .out_data_o(out_data[1]),
        .usage_o(usage_n3), .almost_full_o(af[1]), .almost_empty_o(ae[1])
`ifdef FIFO_ERR_EN
        , .overflow_o(ovf[1]), .underflow_o(unf[1])
`endif
    );

    fifo_v2 #(.DATA_WIDTH(32), .DEPTH(4), .FALL_THROUGH(1),
              .ALMOST_FULL_TH(2), .ALMOST_EMPTY_TH(0)) u_f4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[2]), .in_data_i(in_data_i),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready_i), .out_data_o(out_data[2]),
        .usage_o(usage_f4), .almost_full_o(af[2]), .almost_empty_o(ae[2])
`ifdef FIFO_ERR_EN
        , .overflow_o(ovf[2]), .underflow_o(unf[2])
`endif
    );

    function automatic int depth_of(int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic bit ft_of(int k);
        return (k == 2);
    endfunction

    function automatic int af_th(int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int ae_th(int k);
        return (k == 2) ? 0 : 1;
    endfunction

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s inst%0d at %0t: actual=%0h required=%0h",
                     name, k, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [31:0] d, input logic rd);
        @(posedge clk_i);
        #1;
        rst_i       = r;
        flush_i     = f;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = rd;
    endtask

    // Reference model and per-cycle compare. Expected outputs come from the
    // queue contents; the queue is then advanced by the transfer rules.
    always @(negedge clk_i) begin : model
        int          cnt;
        int          act_use;
        bit          e_rdy;
        bit          e_val;
        bit          do_push;
        bit          do_pop;
        logic [31:0] e_dat;
        for (int k = 0; k < 3; k++) begin
            cnt   = q[k].size();
            e_rdy = (cnt != depth_of(k));
            if (ft_of(k) && cnt == 0) begin
                e_val = in_valid_i;
                e_dat = in_data_i;
            end else begin
                e_val = (cnt != 0);
                e_dat = (cnt != 0) ? q[k][0] : 32'h0;
            end
            act_use = (k == 0) ? int'(usage_n4) :
                      (k == 1) ? int'(usage_n3) : int'(usage_f4);
            if (checking) begin
                checkOutput("in_ready", k, 32'(in_ready[k]), 32'(e_rdy));
                checkOutput("out_valid", k, 32'(out_valid[k]), 32'(e_val));
                if (e_val) checkOutput("out_data", k, out_data[k], e_dat);
                checkOutput("usage", k, 32'(act_use), 32'(cnt));
                checkOutput("almost_full", k, 32'(af[k]), 32'(cnt >= af_th(k)));
                checkOutput("almost_empty", k, 32'(ae[k]), 32'(cnt <= ae_th(k)));
`ifdef FIFO_ERR_EN
                checkOutput("overflow", k, 32'(ovf[k]), 32'(ov_m[k]));
                checkOutput("underflow", k, 32'(unf[k]), 32'(un_m[k]));
`endif
            end
            do_push = in_valid_i && e_rdy;
            do_pop  = e_val && out_ready_i;
            if (rst_i || flush_i) begin
                q[k].delete();
                ov_m[k] = 1'b0;
                un_m[k] = 1'b0;
            end else begin
                ov_m[k] = ov_m[k] | (in_valid_i && !e_rdy);
                un_m[k] = un_m[k] | (out_ready_i && !e_val);
                // Push and pop of an empty fall-through FIFO is a pure bypass.
                if (!(do_push && do_pop && cnt == 0)) begin
                    if (do_pop)  void'(q[k].pop_front());
                    if (do_push) q[k].push_back(in_data_i);
                end
            end
        end
        hold_data = in_valid_i && (in_ready != 3'b111);
    end

    initial begin
        logic [31:0] seq [4];
        seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC; seq[3] = 32'hD;

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
        in_data_i = 32'h0; out_ready_i = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 32'h0, 0);
        checking = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_usage", 0, 32'(usage_n4), 32'd0);
        checkOutput("rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
        checkOutput("rst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        checkOutput("rst_almost_empty", 0, 32'(ae[0]), 32'd1);
        checkOutput("rst_almost_full", 0, 32'(af[0]), 32'd0);

        // Fill with A..D while the consumer stalls
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, seq[i], 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("full_usage", 0, 32'(usage_n4), 32'd4);
        checkOutput("full_in_ready", 0, 32'(in_ready[0]), 32'd0);
        checkOutput("full_almost_full", 0, 32'(af[0]), 32'd1);
        checkOutput("full_usage_d3", 1, 32'(usage_n3), 32'd3);
        checkOutput("full_usage_ft", 2, 32'(usage_f4), 32'd4);

        // Push while full
        applyStimulus(0, 0, 1, 32'hE, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
`ifdef FIFO_ERR_EN
        @(negedge clk_i);
        checkOutput("overflow_set", 0, 32'(ovf[0]), 32'd1);
`endif

        // Drain: head must step through A,B,C,D
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 1);
            @(negedge clk_i);
            checkOutput("pop_order", 0, out_data[0], seq[i]);
        end
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("drained_usage", 0, 32'(usage_n4), 32'd0);
        checkOutput("drained_valid", 0, 32'(out_valid[0]), 32'd0);
`ifdef FIFO_ERR_EN
        checkOutput("overflow_sticky", 0, 32'(ovf[0]), 32'd1);
`endif

        // Pop while empty
        applyStimulus(0, 0, 0, 32'h0, 1);

        // Count 2, then simultaneous push/pop across the wrap point
        applyStimulus(0, 0, 1, 32'h11, 0);
        applyStimulus(0, 0, 1, 32'h12, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 32'h5, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("steady_usage", 0, 32'(usage_n4), 32'd2);

        // Count 3, then flush together with a push of 0x9
        applyStimulus(0, 0, 1, 32'h13, 0);
        applyStimulus(0, 1, 1, 32'h9, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("flush_usage", 0, 32'(usage_n4), 32'd0);
        checkOutput("flush_valid", 0, 32'(out_valid[0]), 32'd0);

        // Fall-through bypass, then fall-through store
        applyStimulus(0, 0, 1, 32'h77, 1);
        @(negedge clk_i);
        checkOutput("ft_valid", 2, 32'(out_valid[2]), 32'd1);
        checkOutput("ft_data", 2, out_data[2], 32'h77);
        checkOutput("ft_usage", 2, 32'(usage_f4), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("ft_bypass_usage", 2, 32'(usage_f4), 32'd0);
        applyStimulus(0, 0, 1, 32'h77, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("ft_store_usage", 2, 32'(usage_f4), 32'd1);
        checkOutput("ft_store_data", 2, out_data[2], 32'h77);

`ifdef FIFO_ERR_EN
        checkOutput("underflow_set", 0, 32'(unf[0]), 32'd1);
        applyStimulus(1, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        checkOutput("rst_overflow", 0, 32'(ovf[0]), 32'd0);
        checkOutput("rst_underflow", 0, 32'(unf[0]), 32'd0);
`endif

        // Randomised traffic: a fill-biased phase, then a drain-biased phase
        for (int i = 0; i < 3000; i++) begin
            logic r, f, v, rd;
            logic [31:0] d;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 31) == 0);
            if (i < 1500) begin
                v  = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 2) == 0);
            end else begin
                v  = ($urandom_range(0, 2) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            d = hold_data ? in_data_i : $urandom;
            applyStimulus(r, f, v, d, rd);
        end

        applyStimulus(0, 0, 0, 32'h0, 0);
        @(negedge clk_i);
        @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
